// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data SRAM port between the instruction fetch
// unit (read-only) and the load/store unit (read/write). One request is in
// flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration;
// otherwise the LSU always wins simultaneous requests.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_req_ready,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    input  logic              lsu_ren,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_req_ready,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              sram_receive_valid,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [7:0]        sram_wmask,
    input  logic              sram_valid,
    input  logic [DATA_W-1:0] sram_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_NULL} op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic              owner_lsu_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
    logic              grant_lsu, grant_ifu, idle, accept;

`ifdef MEM_ARB_RR_EN
    logic prio_lsu_q;

    // Contention is settled by the pointer; a lone requester is always granted.
    always_comb begin
        grant_lsu = lsu_req_valid;
        if (lsu_req_valid && ifu_req_valid)
            grant_lsu = prio_lsu_q;
    end

    // After every grant, hand priority to the requester that was not served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prio_lsu_q <= 1'b1;
        else if (accept)
            prio_lsu_q <= ~grant_lsu;
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif

    assign grant_ifu = ifu_req_valid & ~grant_lsu;
    // Ready is masked while reset is asserted so nothing looks accepted.
    assign idle          = (state_q == IDLE) & rst;
    assign ifu_req_ready = idle & grant_ifu;
    assign lsu_req_ready = idle & grant_lsu;
    assign accept        = ifu_req_ready | lsu_req_ready;

    // Decode the operation of the request being granted; IFU is always a read.
    always_comb begin
        op_d = OP_READ;
        if (grant_lsu) begin
            if (lsu_ren)
                op_d = OP_READ;
            else if (lsu_wen)
                op_d = OP_WRITE;
            else
                op_d = OP_NULL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; reads wait for SRAM data, writes and null accesses do not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = (op_q == OP_READ) ? WAIT : RESP;
            WAIT:    if (sram_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request and capture read data for its owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_lsu_q <= 1'b0;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (accept) begin
                owner_lsu_q <= grant_lsu;
                op_q        <= op_d;
                addr_q      <= grant_lsu ? lsu_addr : ifu_addr;
                wdata_q     <= grant_lsu ? lsu_wdata : '0;
                wmask_q     <= grant_lsu ? lsu_wmask : '0;
            end
            if (state_q == WAIT && sram_valid) begin
                if (owner_lsu_q)
                    lsu_rdata_q <= sram_data;
                else
                    ifu_rdata_q <= sram_data;
            end
        end
    end

    // Strobes and responses are decoded from registered state only.
    assign sram_receive_valid = (state_q == ISSUE) && (op_q != OP_NULL);
    assign sram_ren           = (state_q == ISSUE) && (op_q == OP_READ);
    assign sram_wen           = (state_q == ISSUE) && (op_q == OP_WRITE);
    assign sram_addr          = addr_q;
    assign sram_wdata         = wdata_q;
    assign sram_wmask         = wmask_q;
    assign ifu_resp_valid     = (state_q == RESP) && !owner_lsu_q;
    assign lsu_resp_valid     = (state_q == RESP) && owner_lsu_q;
    assign ifu_rdata          = ifu_rdata_q;
    assign lsu_rdata          = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level
// reference model (grant rule, expected latency, expected read data).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_ren, lsu_wen, lsu_req_ready, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        sram_receive_valid, sram_ren, sram_wen, sram_valid;
    logic [31:0] sram_addr, sram_wdata, sram_data;
    logic [7:0]  sram_wmask;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          rr_lsu_prio;
    logic [31:0] exp_ifu_rdata, exp_lsu_rdata;
    bit          last_win_lsu;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr),
        .ifu_req_ready(ifu_req_ready), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .sram_receive_valid(sram_receive_valid), .sram_ren(sram_ren),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask), .sram_valid(sram_valid), .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spec grant rule: lone requester wins; on contention LSU (fixed) or the
    // requester not served last (round-robin).
    function automatic bit model_grant_lsu(input bit iv, input bit lv);
`ifdef MEM_ARB_RR_EN
        if (iv && lv) return rr_lsu_prio;
`endif
        return lv;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_ready"}, ifu_req_ready, 0);
        check({tag, "_lsu_ready"}, lsu_req_ready, 0);
        check({tag, "_ifu_resp"}, ifu_resp_valid, 0);
        check({tag, "_lsu_resp"}, lsu_resp_valid, 0);
        check({tag, "_strobes"}, {sram_receive_valid, sram_ren, sram_wen}, 0);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_wdata"}, sram_wdata, 0);
        check({tag, "_wmask"}, sram_wmask, 0);
        check({tag, "_ifu_rdata"}, ifu_rdata, 0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 0);
    endtask

    // One complete transaction, starting from an IDLE negedge. dly = cycles
    // from ISSUE to sram_valid (1 means sram_valid in the cycle after ISSUE).
    task automatic do_txn(input bit iv, input bit lv, input bit ren, input bit wen,
                          input int dly, input bit spur,
                          input logic [31:0] ia, input logic [31:0] la,
                          input logic [31:0] wd, input logic [7:0] wm,
                          input logic [31:0] rd);
        bit win_lsu, is_read, is_write;
        win_lsu  = model_grant_lsu(iv, lv);
        is_read  = !win_lsu || ren;
        is_write = win_lsu && !ren && wen;
        // cycle T: request presented, accepted at the next edge
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_ren = ren; lsu_wen = wen;
        lsu_addr = la; lsu_wdata = wd; lsu_wmask = wm;
        if (spur) begin sram_valid = 1'b1; sram_data = $urandom; end
        #1;
        check("ifu_ready", ifu_req_ready, iv && !win_lsu);
        check("lsu_ready", lsu_req_ready, win_lsu);
        rr_lsu_prio  = !win_lsu;
        last_win_lsu = win_lsu;
        // cycle T+1: ISSUE
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        #1;
        check("issue_rcv", sram_receive_valid, is_read || is_write);
        check("issue_ren", sram_ren, is_read);
        check("issue_wen", sram_wen, is_write);
        if (is_read || is_write) check("issue_addr", sram_addr, win_lsu ? la : ia);
        if (is_write) begin
            check("issue_wdata", sram_wdata, wd);
            check("issue_wmask", sram_wmask, wm);
        end
        check("issue_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        sram_valid = 1'b0;
        if (is_read) begin
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                sram_valid = (k == dly);
                sram_data  = (k == dly) ? rd : $urandom;
                #1;
                check("wait_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            end
            if (win_lsu) exp_lsu_rdata = rd;
            else         exp_ifu_rdata = rd;
        end
        // RESP
        @(negedge clk);
        sram_valid = 1'b0;
        #1;
        check("resp_ifu", ifu_resp_valid, !win_lsu);
        check("resp_lsu", lsu_resp_valid, win_lsu);
        check("ifu_rdata", ifu_rdata, exp_ifu_rdata);
        check("lsu_rdata", lsu_rdata, exp_lsu_rdata);
        // back in IDLE: pulse must be gone
        @(negedge clk);
        #1;
        check("idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    endtask

    initial begin
        logic [3:0] seq, exp_seq;
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_ren = 0; lsu_wen = 0;
        lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        sram_valid = 0; sram_data = 0;
        rr_lsu_prio = 1'b1; exp_ifu_rdata = 0; exp_lsu_rdata = 0; last_win_lsu = 0;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Both requesters valid for four transactions, starting from reset priority
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 1'b0, 1'b1, 1, 0, $urandom, $urandom, $urandom, 8'($urandom), $urandom);
            seq[3-i] = last_win_lsu;
        end
`ifdef MEM_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        check("grant_seq", seq, exp_seq);

        // IFU read, data two cycles after ISSUE
        do_txn(1, 0, 0, 0, 2, 0, 32'h8000_0000, 0, 0, 0, 32'h0000_0413);
        // LSU write with partial mask
        do_txn(0, 1, 0, 1, 1, 0, 0, 32'h8000_1000, 32'hdead_beef, 8'h0f, 0);
        // LSU ren and wen both set: read
        do_txn(0, 1, 1, 1, 1, 0, 0, $urandom, $urandom, 8'($urandom), 32'h1234_5678);
        // LSU null access
        do_txn(0, 1, 0, 0, 1, 0, 0, $urandom, $urandom, 8'($urandom), 0);
        // spurious sram_valid in IDLE/ISSUE plus a 20-cycle SRAM stall
        do_txn(1, 0, 0, 0, 21, 1, $urandom, 0, 0, 0, $urandom);

        // spurious sram_valid with nothing outstanding
        for (int i = 0; i < 3; i++) begin
            sram_valid = 1'b1; sram_data = $urandom;
            @(negedge clk);
            #1;
            check("spur_idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
            check("spur_idle_ifu_rdata", ifu_rdata, exp_ifu_rdata);
            check("spur_idle_lsu_rdata", lsu_rdata, exp_lsu_rdata);
        end
        sram_valid = 1'b0;
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit iv, lv;
            iv = 1'($urandom);
            lv = 1'($urandom);
            if (!iv && !lv) lv = 1'b1;
            do_txn(iv, lv, 1'($urandom), 1'($urandom), $urandom_range(1, 4),
                   1'($urandom), $urandom, $urandom, $urandom, 8'($urandom), $urandom);
        end

        // reset asserted while a read is waiting
        ifu_req_valid = 1'b1; ifu_addr = $urandom;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("prerst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_ifu_rdata = 0; exp_lsu_rdata = 0; rr_lsu_prio = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        sram_valid = 1'b1; sram_data = $urandom;
        #1;
        check("late_valid_resp0", {ifu_resp_valid, lsu_resp_valid}, 0);
        @(negedge clk);
        sram_valid = 1'b0;
        #1;
        check("late_valid_resp1", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("late_valid_rdata", {ifu_rdata, lsu_rdata}, 0);
        @(negedge clk);
        #1;
        check("late_valid_resp2", {ifu_resp_valid, lsu_resp_valid}, 0);
        do_txn(1, 1, 1, 0, 2, 0, $urandom, $urandom, $urandom, 8'($urandom), $urandom);
        check("postrst_grant_lsu", last_win_lsu, 1);
        do_txn(1, 0, 0, 0, 1, 0, $urandom, 0, 0, 0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
